// File: rtl/ifm_window_reader.sv
// Streams the zero-padded feature map to the depthwise PE array in 3x3 window order.
// Reads are credit-limited so a small FWFT FIFO can absorb all consumer backpressure.
module ifm_window_reader #(
  parameter int unsigned PE         = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        IFM_C,
  input  logic [7:0]        IFM_W,
  input  logic              padding,
  input  logic              stride,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [31:0]       rd_addr,
  input  logic [PE*8-1:0]   rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PE*8-1:0]   out_data,
  output logic [3:0]        out_tap,
  output logic              out_last_tap,
  output logic              out_last_pixel
);
  localparam int unsigned DW = PE * 8;
  localparam int unsigned TW = 6;
  localparam int unsigned EW = DW + TW;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cfg_cb_q, cfg_cb_d;
  logic [7:0]    cfg_w_q, cfg_w_d;
  logic          cfg_pad_q, cfg_pad_d, cfg_str_q, cfg_str_d;
  logic [7:0]    oy_q, oy_d, ox_q, ox_d;
  logic [3:0]    cb_q, cb_d;
  logic [1:0]    ky_q, ky_d, kx_q, kx_d;
  logic          rd_en_q, rd_en_d;
  logic [31:0]   rd_addr_q, rd_addr_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          issue;

  logic [CW-1:0] outst_q, outst_d, cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic          out_valid_q;
  logic          vld_pipe_q [RD_LAT];
  logic [TW-1:0] tag_pipe_q [RD_LAT];
  logic          push, pop;

  // In IDLE the live inputs drive the geometry so the first read can go out right after start.
  logic [3:0]  ecb;
  logic [7:0]  ew;
  logic        ep, es;
  logic [31:0] wp, ow, cb_n, row, col, addr_c;
  logic        degen, credit_ok, cb_last, ox_last, oy_last, is_last;
  logic [3:0]  tap_c;
  logic        last_tap_c, last_pix_c;
  logic        unused_c;

  assign unused_c   = ^IFM_C[3:0];
  assign ecb        = (state_q == S_IDLE) ? IFM_C[7:4] : cfg_cb_q;
  assign ew         = (state_q == S_IDLE) ? IFM_W      : cfg_w_q;
  assign ep         = (state_q == S_IDLE) ? padding    : cfg_pad_q;
  assign es         = (state_q == S_IDLE) ? stride     : cfg_str_q;
  assign wp         = 32'(ew) + (ep ? 32'd2 : 32'd0);
  assign cb_n       = 32'(ecb);
  assign degen      = (cb_n == 32'd0) || (wp < 32'd3);
  assign ow         = ((wp - 32'd3) >> es) + 32'd1;
  assign row        = (es ? (32'(oy_q) << 1) : 32'(oy_q)) + 32'(ky_q);
  assign col        = (es ? (32'(ox_q) << 1) : 32'(ox_q)) + 32'(kx_q);
  assign addr_c     = (((row * wp) + col) * cb_n << 2) + (32'(cb_q) << 2);
  assign tap_c      = 4'(ky_q) * 4'd3 + 4'(kx_q);
  assign last_tap_c = (ky_q == 2'd2) && (kx_q == 2'd2);
  assign cb_last    = (32'(cb_q) == cb_n - 32'd1);
  assign ox_last    = (32'(ox_q) == ow - 32'd1);
  assign oy_last    = (32'(oy_q) == ow - 32'd1);
  assign last_pix_c = ox_last && oy_last;
  assign is_last    = last_tap_c && cb_last && ox_last && oy_last;
  // Credit covers both queued entries and reads whose data has not yet landed.
  assign credit_ok  = (32'(cnt_q) + 32'(outst_q)) < FIFO_DEPTH;
  assign push       = vld_pipe_q[RD_LAT-1];
  assign pop        = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cfg_cb_q  <= '0;
      cfg_w_q   <= '0;
      cfg_pad_q <= 1'b0;
      cfg_str_q <= 1'b0;
      oy_q      <= '0;
      ox_q      <= '0;
      cb_q      <= '0;
      ky_q      <= '0;
      kx_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tag_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_cb_q  <= cfg_cb_d;
      cfg_w_q   <= cfg_w_d;
      cfg_pad_q <= cfg_pad_d;
      cfg_str_q <= cfg_str_d;
      oy_q      <= oy_d;
      ox_q      <= ox_d;
      cb_q      <= cb_d;
      ky_q      <= ky_d;
      kx_q      <= kx_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      tag_q     <= tag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_cb_d  = cfg_cb_q;
    cfg_w_d   = cfg_w_q;
    cfg_pad_d = cfg_pad_q;
    cfg_str_d = cfg_str_q;
    oy_d      = oy_q;
    ox_d      = ox_q;
    cb_d      = cb_q;
    ky_d      = ky_q;
    kx_d      = kx_q;
    issue     = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    tag_d     = tag_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_cb_d  = IFM_C[7:4];
          cfg_w_d   = IFM_W;
          cfg_pad_d = padding;
          cfg_str_d = stride;
          if (degen) begin
            state_d = S_DRAIN;
          end else begin
            issue   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (is_last) state_d = S_DRAIN;
        end
      end
      // Finish as soon as the last queued beat is leaving this cycle.
      S_DRAIN: begin
        if ((outst_q == '0) && ((cnt_q == '0) || ((cnt_q == CW'(1)) && pop))) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        oy_d    = '0;
        ox_d    = '0;
        cb_d    = '0;
        ky_d    = '0;
        kx_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      rd_en_d   = 1'b1;
      rd_addr_d = addr_c;
      tag_d     = {tap_c, last_tap_c, last_pix_c};
      kx_d      = kx_q + 2'd1;
      if (kx_q == 2'd2) begin
        kx_d = '0;
        ky_d = ky_q + 2'd1;
        if (ky_q == 2'd2) begin
          ky_d = '0;
          cb_d = cb_q + 4'd1;
          if (cb_last) begin
            cb_d = '0;
            ox_d = ox_q + 8'd1;
            if (ox_last) begin
              ox_d = '0;
              oy_d = oy_q + 8'd1;
            end
          end
        end
      end
    end
    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  assign outst_d = outst_q + CW'(issue) - CW'(push);
  assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

  // Tag pipeline tracks the buffer latency; FIFO stores returned beat with its tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= 1'b0;
        tag_pipe_q[i] <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      outst_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vld_pipe_q[0] <= rd_en_q;
      tag_pipe_q[0] <= tag_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
      if (push) begin
        mem_q[wr_ptr_q] <= {rd_data, tag_pipe_q[RD_LAT-1]};
        wr_ptr_q        <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      cnt_q       <= cnt_d;
      outst_q     <= outst_d;
      out_valid_q <= (cnt_d != '0);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign {out_data, out_tap, out_last_tap, out_last_pixel} = mem_q[rd_ptr_q];

endmodule
